ghr_ctrl: RTL and testbench
===========================

GHR_CTRL -- requirements
Module: ghr_ctrl

Interface
REQ-001 Parameter GHR_WIDTH, default 8, global history length in bits; minimum 2.
REQ-002 Parameter QDEPTH, default 4, PHT-update queue depth; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 if1_br_valid  input  1  IF1 predicted a conditional branch this cycle.
REQ-006 if1_pred_taken  input  1  IF1 prediction, 1 = taken.
REQ-007 if1_stall  input  1  IF1 held; its prediction is not consumed this cycle.
REQ-008 ex_br_valid  input  1  EX resolved a conditional branch this cycle.
REQ-009 ex_branched  input  1  resolved direction, 1 = taken.
REQ-010 ex_mispredict  input  1  resolved direction differs from the prediction; qualified by ex_br_valid.
REQ-011 ex_pc  input  32  PC of the resolved branch.
REQ-012 ex_ghr_snap  input  GHR_WIDTH  ghr_spec value used when this branch was predicted.
REQ-013 flush  input  1  pipeline flush (exception/ertn); speculative history is discarded.
REQ-014 upd_hold  input  1  PHT write port unavailable this cycle.
REQ-015 ghr_spec  output  GHR_WIDTH  speculative history driven to the PHT read index.
REQ-016 ghr_arch  output  GHR_WIDTH  committed history.
REQ-017 pht_we, pht_branched  output  1 each  PHT write strobe and written direction.
REQ-018 pht_pc, pht_ghr  output  32, GHR_WIDTH  PC and history of the entry being written.
REQ-019 upd_full  output  1  update queue holds QDEPTH entries.
REQ-020 drop_cnt  output  8  saturating count of resolved branches lost to a full queue.
REQ-021 recovering  output  1  FSM is in RECOVER.

Function
REQ-022 FSM states: RUN, RECOVER; reset state RUN.
REQ-023 RUN -> RECOVER on ex_br_valid & ex_mispredict; RECOVER -> RUN unconditionally after 1 cycle, or stays in RECOVER if another mispredict arrives that cycle.
REQ-024 Mispredict (ex_br_valid & ex_mispredict), any state: ghr_spec <= {ex_ghr_snap[GHR_WIDTH-2:0], ex_branched}.
REQ-025 Else flush: ghr_spec <= next-cycle value of ghr_arch, including any same-cycle EX shift.
REQ-026 Else in RUN with if1_br_valid & !if1_stall: ghr_spec <= {ghr_spec[GHR_WIDTH-2:0], if1_pred_taken}.
REQ-027 In RECOVER, if1_br_valid is ignored; it is wrong-path.
REQ-028 Update priority: mispredict > flush > IF1 shift > hold.
REQ-029 On every ex_br_valid: ghr_arch <= {ghr_arch[GHR_WIDTH-2:0], ex_branched}, independent of flush and FSM state.
REQ-030 Queue push on ex_br_valid of {ex_pc, ex_ghr_snap, ex_branched}; push is accepted when not full, or when full and a pop occurs the same cycle.
REQ-031 A rejected push increments drop_cnt, saturating at 255, and changes no other state.
REQ-032 Pop occurs when the queue is non-empty & !upd_hold.
- pht_we = non-empty & !upd_hold, combinational.
- pht_pc, pht_ghr, pht_branched are the head entry.
REQ-033 An entry pushed at edge N is writable at the earliest in cycle N+1; there is no bypass from EX to the PHT port.
REQ-034 flush and RECOVER do not clear the queue; resolved branches always train.
REQ-035 Queue pointers wrap modulo QDEPTH; occupancy counter width is clog2(QDEPTH)+1; upd_full = (count == QDEPTH).

Reset
REQ-036 While rst is high, all registers are cleared asynchronously:
- ghr_spec = 0, ghr_arch = 0, drop_cnt = 0, queue empty, state RUN.
- pht_we = 0, upd_full = 0, recovering = 0.
REQ-037 Reset asserted mid-operation discards queued updates and returns the block to REQ-036 values within the same cycle.

Verification
REQ-038 Reset, then IF1 predicts T,T,N with no stall -> ghr_spec goes 0x01, 0x03, 0x06 on successive cycles; ghr_arch stays 0x00.
REQ-039 ghr_spec=0x5A; ex mispredict with snap=0x33 and branched=1, while if1_br_valid=1 the same cycle -> ghr_spec=0x67 and recovering=1 next cycle; a following if1_br_valid is ignored; then state RUN.
REQ-040 upd_hold=1 with 5 consecutive ex_br_valid -> upd_full=1 after the 4th; the 5th is dropped and drop_cnt=1; release hold -> pht_we=1 for 4 cycles in push order with matching pc/ghr/branched.
REQ-041 Queue full with upd_hold=0 and ex_br_valid -> push accepted with simultaneous pop; drop_cnt unchanged; upd_full stays 1.
REQ-042 ghr_arch=0x0F; flush with ex_br_valid branched=0 the same cycle -> ghr_arch=0x1E and ghr_spec=0x1E next cycle; queue contents retained.
REQ-043 rst pulsed mid-cycle with 3 entries queued and ghr_spec=0xFF -> outputs immediately 0; pht_we=0; no write follows after deassertion.

Source files
------------

// File: rtl/ghr_ctrl.sv
// Global branch history controller: speculative/committed GHR tracking, mispredict
// recovery FSM, and a small FIFO that serializes resolved branches onto the PHT write port.
module ghr_ctrl #(
   parameter int GHR_WIDTH = 8,
   parameter int QDEPTH    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if1_br_valid,
   input  logic                 if1_pred_taken,
   input  logic                 if1_stall,
   input  logic                 ex_br_valid,
   input  logic                 ex_branched,
   input  logic                 ex_mispredict,
   input  logic [31:0]          ex_pc,
   input  logic [GHR_WIDTH-1:0] ex_ghr_snap,
   input  logic                 flush,
   input  logic                 upd_hold,
   output logic [GHR_WIDTH-1:0] ghr_spec,
   output logic [GHR_WIDTH-1:0] ghr_arch,
   output logic                 pht_we,
   output logic                 pht_branched,
   output logic [31:0]          pht_pc,
   output logic [GHR_WIDTH-1:0] pht_ghr,
   output logic                 upd_full,
   output logic [7:0]           drop_cnt,
   output logic                 recovering
);

   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] RECOVER = 1'b1;

   typedef struct packed {
      logic [31:0]          pc;
      logic [GHR_WIDTH-1:0] ghr;
      logic                 br;
   } upd_t;

   logic [0:0]           state_q, state_d;
   logic [GHR_WIDTH-1:0] spec_q, spec_d;
   logic [GHR_WIDTH-1:0] arch_q, arch_d;
   logic [7:0]           drop_q, drop_d;
   logic [AW-1:0]        wptr_q, rptr_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   upd_t                 mem_q [QDEPTH];

   logic mispred, empty, full, pop, push, drop;

   assign mispred = ex_br_valid & ex_mispredict;
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(QDEPTH));
   assign pop     = !empty & !upd_hold;
   // A full queue still accepts when the head drains in the same cycle.
   assign push    = ex_br_valid & (!full | pop);
   assign drop    = ex_br_valid & full & !pop;

   always_comb begin
      arch_d = ex_br_valid ? {arch_q[GHR_WIDTH-2:0], ex_branched} : arch_q;
      spec_d = spec_q;
      if (mispred)
         spec_d = {ex_ghr_snap[GHR_WIDTH-2:0], ex_branched};
      else if (flush)
         spec_d = arch_d;
      else if (state_q == RUN && if1_br_valid && !if1_stall)
         spec_d = {spec_q[GHR_WIDTH-2:0], if1_pred_taken};
   end

   always_comb begin
      state_d = mispred ? RECOVER : RUN;
      drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      cnt_d   = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         spec_q  <= '0;
         arch_q  <= '0;
         drop_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         spec_q  <= spec_d;
         arch_q  <= arch_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         if (push) begin
            mem_q[wptr_q] <= '{pc: ex_pc, ghr: ex_ghr_snap, br: ex_branched};
            wptr_q        <= wptr_q + AW'(1);
         end
         if (pop) rptr_q <= rptr_q + AW'(1);
      end
   end

   assign ghr_spec     = spec_q;
   assign ghr_arch     = arch_q;
   assign pht_we       = pop;
   assign pht_pc       = mem_q[rptr_q].pc;
   assign pht_ghr      = mem_q[rptr_q].ghr;
   assign pht_branched = mem_q[rptr_q].br;
   assign upd_full     = full;
   assign drop_cnt     = drop_q;
   assign recovering   = (state_q == RECOVER);

endmodule

// File: tb/tb_ghr_ctrl.sv
// Directed bench for ghr_ctrl: expected PHT writes go into a scoreboard queue drained
// by a negedge monitor; history/status outputs are checked against hand-computed constants.
module tb_ghr_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        if1_br_valid, if1_pred_taken, if1_stall;
   logic        ex_br_valid, ex_branched, ex_mispredict;
   logic [31:0] ex_pc;
   logic [7:0]  ex_ghr_snap;
   logic        flush, upd_hold;
   logic [7:0]  ghr_spec, ghr_arch, pht_ghr, drop_cnt;
   logic        pht_we, pht_branched, upd_full, recovering;
   logic [31:0] pht_pc;

   int n_cmp = 0;
   int n_bad = 0;
   logic [40:0] sb [$];

   ghr_ctrl #(.GHR_WIDTH(8), .QDEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .if1_br_valid(if1_br_valid), .if1_pred_taken(if1_pred_taken), .if1_stall(if1_stall),
      .ex_br_valid(ex_br_valid), .ex_branched(ex_branched), .ex_mispredict(ex_mispredict),
      .ex_pc(ex_pc), .ex_ghr_snap(ex_ghr_snap), .flush(flush), .upd_hold(upd_hold),
      .ghr_spec(ghr_spec), .ghr_arch(ghr_arch), .pht_we(pht_we), .pht_branched(pht_branched),
      .pht_pc(pht_pc), .pht_ghr(pht_ghr), .upd_full(upd_full), .drop_cnt(drop_cnt),
      .recovering(recovering)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_ex(input logic v, input logic mp, input logic br,
                         input logic [31:0] pc, input logic [7:0] snap);
      ex_br_valid = v; ex_mispredict = mp; ex_branched = br; ex_pc = pc; ex_ghr_snap = snap;
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [7:0] g, input logic br);
      sb.push_back({pc, g, br});
   endtask

   // Scoreboard monitor: every PHT write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (pht_we) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL pht_unexpected: got pc=0x%0h ghr=0x%0h br=%0d expected no write",
                     pht_pc, pht_ghr, pht_branched);
         end else begin
            logic [40:0] e;
            e = sb.pop_front();
            chk("pht_entry", {pht_pc[22:0], pht_ghr, pht_branched}, {e[31:9], e[8:0]});
            chk("pht_pc_hi", {23'd0, pht_pc[31:23]}, {23'd0, e[40:32]});
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 0; upd_hold = 0;
      if1_br_valid = 0; if1_pred_taken = 0; if1_stall = 0;
      set_ex(0, 0, 0, 32'h0, 8'h0);
      tick(); tick();
      chk("rst_spec", ghr_spec, 0);
      chk("rst_arch", ghr_arch, 0);
      chk("rst_we", pht_we, 0);
      chk("rst_full", upd_full, 0);
      chk("rst_recov", recovering, 0);
      chk("rst_drop", drop_cnt, 0);
      rst = 1'b0;

      // IF1 predictions T,T,N
      if1_br_valid = 1; if1_pred_taken = 1; tick(); chk("if1_t1", ghr_spec, 8'h01);
      tick(); chk("if1_t2", ghr_spec, 8'h03);
      if1_pred_taken = 0; tick(); chk("if1_n", ghr_spec, 8'h06);
      chk("if1_arch", ghr_arch, 8'h00);
      if1_stall = 1; if1_pred_taken = 1; tick(); chk("if1_stall", ghr_spec, 8'h06);
      if1_stall = 0; if1_br_valid = 0;

      // Mispredict to set spec=0x5A, then the recovery scenario
      set_ex(1, 1, 0, 32'h1000, 8'h2D); push_exp(32'h1000, 8'h2D, 0);
      tick(); chk("mp1_spec", ghr_spec, 8'h5A); chk("mp1_recov", recovering, 1);
      set_ex(0, 0, 0, 0, 0);
      tick(); chk("mp1_run", recovering, 0); chk("mp1_hold", ghr_spec, 8'h5A);
      set_ex(1, 1, 1, 32'h2000, 8'h33); push_exp(32'h2000, 8'h33, 1);
      if1_br_valid = 1; if1_pred_taken = 1;
      tick(); chk("mp2_spec", ghr_spec, 8'h67); chk("mp2_recov", recovering, 1);
      chk("mp2_arch", ghr_arch, 8'h01);
      set_ex(0, 0, 0, 0, 0);
      tick(); chk("recov_ign", ghr_spec, 8'h67); chk("recov_exit", recovering, 0);
      if1_br_valid = 0;
      tick(); tick();

      // Fill under hold, overflow, then push+pop on full
      upd_hold = 1;
      for (int i = 0; i < 5; i++) begin
         set_ex(1, 0, i[0], 32'h100 + 32'(i * 4), 8'(i * 8'h11));
         if (i < 4) push_exp(32'h100 + 32'(i * 4), 8'(i * 8'h11), i[0]);
         tick();
         if (i == 2) chk("full_at3", upd_full, 0);
         if (i == 3) chk("full_at4", upd_full, 1);
      end
      chk("drop_1", drop_cnt, 1);
      upd_hold = 0;
      set_ex(1, 0, 1, 32'h200, 8'h77); push_exp(32'h200, 8'h77, 1);
      tick(); chk("pp_drop", drop_cnt, 1); chk("pp_full", upd_full, 1);
      set_ex(0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) tick();
      chk("drained", upd_full, 0);

      // drop_cnt saturation
      upd_hold = 1;
      for (int i = 0; i < 4; i++) begin
         set_ex(1, 0, 0, 32'h400 + 32'(i), 8'h40 + 8'(i)); push_exp(32'h400 + 32'(i), 8'h40 + 8'(i), 0);
         tick();
      end
      set_ex(1, 0, 1, 32'hDEAD, 8'hEE);
      for (int i = 0; i < 260; i++) tick();
      chk("drop_sat", drop_cnt, 8'hFF);
      set_ex(0, 0, 0, 0, 0); upd_hold = 0;
      for (int i = 0; i < 6; i++) tick();

      // Fresh reset, then flush + same-cycle EX shift
      rst = 1; sb.delete(); tick(); rst = 0;
      chk("rst2_drop", drop_cnt, 0);
      upd_hold = 1;
      for (int i = 0; i < 4; i++) begin
         set_ex(1, 0, 1, 32'h300 + 32'(i * 4), 8'h10 + 8'(i)); push_exp(32'h300 + 32'(i * 4), 8'h10 + 8'(i), 1);
         tick();
      end
      chk("fl_arch0", ghr_arch, 8'h0F); chk("fl_spec0", ghr_spec, 8'h00);
      upd_hold = 0; flush = 1; if1_br_valid = 1; if1_pred_taken = 1;
      set_ex(1, 0, 0, 32'h310, 8'h20); push_exp(32'h310, 8'h20, 0);
      tick(); chk("fl_arch", ghr_arch, 8'h1E); chk("fl_spec", ghr_spec, 8'h1E);
      chk("fl_drop", drop_cnt, 0); chk("fl_full", upd_full, 1);
      flush = 0; if1_br_valid = 0; set_ex(0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) tick();

      // Mid-cycle reset with queued entries
      upd_hold = 1;
      set_ex(1, 0, 0, 32'h500, 8'h01); tick();
      set_ex(1, 0, 1, 32'h504, 8'h02); tick();
      set_ex(1, 1, 1, 32'h508, 8'h7F); tick();
      set_ex(0, 0, 0, 0, 0);
      chk("pre_spec", ghr_spec, 8'hFF);
      #2 rst = 1; #1;
      chk("mr_spec", ghr_spec, 0); chk("mr_arch", ghr_arch, 0);
      chk("mr_we", pht_we, 0); chk("mr_full", upd_full, 0); chk("mr_recov", recovering, 0);
      upd_hold = 0; #1 rst = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("mr_nowrite", pht_we, 0);
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
